// File: rtl/counter_pkg.sv
// Shared definitions for the board counter family: direction encodings and
// an elaboration-time ceiling-log2 used to size-check counter parameters.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 32'sd0;
        remain = value - 32'sd1;
        while (remain > 32'sd0) begin
            result = result + 32'sd1;
            remain = remain >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event tally: increments once per INC cycle and sticks at all-ones.
module sat_counter
    import counter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         INC,
    output logic [W-1:0] CNT
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_next_s;

    // Next tally value; never rolls over once saturated.
    always_comb begin
        cnt_next_s = cnt_r;
        if (INC && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Tally register with asynchronous active-low clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_r <= {W{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign CNT = cnt_r;

endmodule

// File: rtl/mod_n_counter.sv
// Parametrised up/down modulo-N counter with parallel load, terminal-count
// pulse, wrap-toggled LED and a saturating wrap tally for cascaded displays.
module mod_n_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8,
    parameter int WRAP_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I,
    input  logic              DIR,
    input  logic              LOAD,
    input  logic [WIDTH-1:0]  D,
    output logic [WIDTH-1:0]  Q,
    output logic              TC,
    output logic              LED,
    output logic [WRAP_W-1:0] WRAPS
);

    generate
        if ((MODULUS < 2) || (clog2(MODULUS) > WIDTH)) begin : g_bad_modulus
            $error("mod_n_counter: MODULUS must lie in 2 .. 2**WIDTH");
        end
    endgenerate

    // Compares and steps use one extra bit so MODULUS == 2**WIDTH stays exact.
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   TERM_EXT = MOD_EXT - (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] TERM     = TERM_EXT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic             led_r;
    logic [WIDTH:0]   q_ext_s;
    logic [WIDTH:0]   d_ext_s;
    logic [WIDTH:0]   step_ext_s;
    logic [WIDTH-1:0] q_next_s;
    logic             wrap_s;

    assign q_ext_s = {1'b0, q_r};
    assign d_ext_s = {1'b0, D};

    // Next count and wrap detection: load beats count, count beats hold.
    always_comb begin
        step_ext_s = q_ext_s;
        q_next_s   = q_r;
        wrap_s     = 1'b0;
        if (LOAD) begin
            if (d_ext_s < MOD_EXT) begin
                q_next_s = D;
            end else begin
                q_next_s = TERM;
            end
        end else if (I) begin
            if (q_ext_s >= MOD_EXT) begin
                // Unreachable state: recover to zero without flagging a wrap.
                q_next_s = ZERO;
            end else if (DIR == DIR_UP) begin
                if (q_ext_s == TERM_EXT) begin
                    q_next_s = ZERO;
                    wrap_s   = 1'b1;
                end else begin
                    step_ext_s = q_ext_s + (WIDTH+1)'(1);
                    q_next_s   = step_ext_s[WIDTH] ? ZERO : step_ext_s[WIDTH-1:0];
                end
            end else begin
                if (q_ext_s == {(WIDTH+1){1'b0}}) begin
                    q_next_s = TERM;
                    wrap_s   = 1'b1;
                end else begin
                    step_ext_s = q_ext_s - (WIDTH+1)'(1);
                    q_next_s   = step_ext_s[WIDTH] ? ZERO : step_ext_s[WIDTH-1:0];
                end
            end
        end else begin
            q_next_s = q_r;
        end
    end

    // Count, terminal-count pulse and LED state registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q_r   <= ZERO;
            tc_r  <= 1'b0;
            led_r <= 1'b0;
        end else begin
            q_r   <= q_next_s;
            tc_r  <= wrap_s;
            led_r <= led_r ^ wrap_s;
        end
    end

    sat_counter #(
        .W (WRAP_W)
    ) u_wraps (
        .CLK (CLK),
        .RST (RST),
        .INC (wrap_s),
        .CNT (WRAPS)
    );

    assign Q   = q_r;
    assign TC  = tc_r;
    assign LED = led_r;

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench for mod_n_counter: three configurations checked every cycle
// against an arithmetic reference model plus hand-computed expectations.
module tb_mod_n_counter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       i_s    [3];
    logic       dir_s  [3];
    logic       load_s [3];
    logic [3:0] d_s    [3];

    logic [2:0] q0;
    logic [3:0] q1;
    logic [0:0] q2;
    logic       tc0, tc1, tc2;
    logic       led0, led1, led2;
    logic [3:0] w0;
    logic [3:0] w1;
    logic [1:0] w2;

    mod_n_counter #(.WIDTH(3), .MODULUS(8), .WRAP_W(4)) u0 (
        .CLK(clk), .RST(rst), .I(i_s[0]), .DIR(dir_s[0]), .LOAD(load_s[0]),
        .D(d_s[0][2:0]), .Q(q0), .TC(tc0), .LED(led0), .WRAPS(w0));

    mod_n_counter #(.WIDTH(4), .MODULUS(10), .WRAP_W(4)) u1 (
        .CLK(clk), .RST(rst), .I(i_s[1]), .DIR(dir_s[1]), .LOAD(load_s[1]),
        .D(d_s[1][3:0]), .Q(q1), .TC(tc1), .LED(led1), .WRAPS(w1));

    mod_n_counter #(.WIDTH(1), .MODULUS(2), .WRAP_W(2)) u2 (
        .CLK(clk), .RST(rst), .I(i_s[2]), .DIR(dir_s[2]), .LOAD(load_s[2]),
        .D(d_s[2][0:0]), .Q(q2), .TC(tc2), .LED(led2), .WRAPS(w2));

    localparam int MODV [3] = '{8, 10, 2};
    localparam int WMAX [3] = '{15, 15, 3};
    localparam int DMASK[3] = '{7, 15, 1};

    int mq[3], mtc[3], mled[3], mwr[3];
    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    int seq2[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    int seq3[3] = '{9, 8, 7};
    int pat6[4] = '{1, 0, 1, 0};
    int seq6[4] = '{1, 1, 2, 2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: modular arithmetic on plain integers.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                mq[k] <= 0; mtc[k] <= 0; mled[k] <= 0; mwr[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin : g_step
                int nq;
                int w;
                int dv;
                nq = mq[k];
                w = 0;
                dv = int'(d_s[k]) & DMASK[k];
                if (load_s[k]) begin
                    nq = (dv >= MODV[k]) ? MODV[k] - 1 : dv;
                end else if (i_s[k]) begin
                    if (dir_s[k]) begin
                        nq = (mq[k] + 1) % MODV[k];
                        w = (mq[k] + 1 == MODV[k]) ? 1 : 0;
                    end else begin
                        nq = (mq[k] + MODV[k] - 1) % MODV[k];
                        w = (mq[k] == 0) ? 1 : 0;
                    end
                end
                mq[k] <= nq;
                mtc[k] <= w;
                if (w != 0) begin
                    mled[k] <= 1 - mled[k];
                    mwr[k] <= (mwr[k] < WMAX[k]) ? mwr[k] + 1 : mwr[k];
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_q0",   {29'd0, q0},   mq[0]);
            chk("cyc_tc0",  {31'd0, tc0},  mtc[0]);
            chk("cyc_led0", {31'd0, led0}, mled[0]);
            chk("cyc_w0",   {28'd0, w0},   mwr[0]);
            chk("cyc_q1",   {28'd0, q1},   mq[1]);
            chk("cyc_tc1",  {31'd0, tc1},  mtc[1]);
            chk("cyc_led1", {31'd0, led1}, mled[1]);
            chk("cyc_w1",   {28'd0, w1},   mwr[1]);
            chk("cyc_q2",   {31'd0, q2},   mq[2]);
            chk("cyc_tc2",  {31'd0, tc2},  mtc[2]);
            chk("cyc_led2", {31'd0, led2}, mled[2]);
            chk("cyc_w2",   {30'd0, w2},   mwr[2]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_s[k] = 1'b1; dir_s[k] = 1'b1; load_s[k] = 1'b0; d_s[k] = 4'd0;
        end
        @(posedge clk);
        check_en = 1'b1;
        tick();
        chk("rst_q0", {29'd0, q0}, 32'd0);
        chk("rst_tc0", {31'd0, tc0}, 32'd0);
        chk("rst_led0", {31'd0, led0}, 32'd0);
        chk("rst_w0", {28'd0, w0}, 32'd0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) i_s[k] = 1'b0;

        // Default config counts up across one wrap.
        i_s[0] = 1'b1; dir_s[0] = 1'b1;
        for (int n = 0; n < 9; n++) begin
            tick();
            chk("up8_q", {29'd0, q0}, seq2[n]);
            chk("up8_tc", {31'd0, tc0}, (n == 7) ? 32'd1 : 32'd0);
        end
        chk("up8_led", {31'd0, led0}, 32'd1);
        chk("up8_wraps", {28'd0, w0}, 32'd1);
        i_s[0] = 1'b0;

        // Mod-10 counting down from reset wraps immediately to 9.
        i_s[1] = 1'b1; dir_s[1] = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("dn10_q", {28'd0, q1}, seq3[n]);
            chk("dn10_tc", {31'd0, tc1}, (n == 0) ? 32'd1 : 32'd0);
        end
        chk("dn10_led", {31'd0, led1}, 32'd1);

        // Out-of-range load clamps and beats the count step.
        load_s[1] = 1'b1; d_s[1] = 4'd12; i_s[1] = 1'b1;
        tick();
        chk("ld_q", {28'd0, q1}, 32'd9);
        chk("ld_tc", {31'd0, tc1}, 32'd0);
        chk("ld_wraps", {28'd0, w1}, 32'd1);
        load_s[1] = 1'b0; dir_s[1] = 1'b1;
        tick();
        chk("ld_next_q", {28'd0, q1}, 32'd0);
        chk("ld_next_tc", {31'd0, tc1}, 32'd1);
        chk("ld_next_wraps", {28'd0, w1}, 32'd2);
        i_s[1] = 1'b0;

        // Mod-2 with narrow tally: back-to-back wraps and saturation.
        i_s[2] = 1'b1; dir_s[2] = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            chk("m2_q", {31'd0, q2}, (n % 2 == 1) ? 32'd1 : 32'd0);
            chk("m2_tc", {31'd0, tc2}, (n % 2 == 0) ? 32'd1 : 32'd0);
        end
        chk("m2_led", {31'd0, led2}, 32'd1);
        chk("m2_wraps_sat", {30'd0, w2}, 32'd3);
        i_s[2] = 1'b0;

        // Enable gating from zero.
        load_s[0] = 1'b1; d_s[0] = 4'd0;
        tick();
        load_s[0] = 1'b0; dir_s[0] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            i_s[0] = pat6[n][0];
            tick();
            chk("gate_q", {29'd0, q0}, seq6[n]);
            chk("gate_tc", {31'd0, tc0}, 32'd0);
        end
        i_s[0] = 1'b0;

        // Asynchronous reset mid-count clears without a clock edge.
        load_s[0] = 1'b1; d_s[0] = 4'd5;
        tick();
        load_s[0] = 1'b0;
        chk("pre_arst_q", {29'd0, q0}, 32'd5);
        chk("pre_arst_led", {31'd0, led0}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_q", {29'd0, q0}, 32'd0);
        chk("arst_led", {31'd0, led0}, 32'd0);
        chk("arst_wraps", {28'd0, w0}, 32'd0);
        chk("arst_q1", {28'd0, q1}, 32'd0);
        tick();
        rst = 1'b1;
        i_s[0] = 1'b1; dir_s[0] = 1'b1;
        tick();
        chk("post_arst_q", {29'd0, q0}, 32'd1);
        i_s[0] = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
